// File: rtl/sprite_line_engine_if.sv
// Pin bundle between the sprite line engine and its host: RAM ports, pixel read port, control.
// The engine side uses the slave modport; the host/RAM side uses master.
interface sprite_line_engine_if #(
    parameter int SA_W = 6
) ();
    logic [7:0]      next_row;
    logic            prep;
    logic            enable;
    logic [SA_W-1:0] sprram_addr;
    logic [63:0]     sprram_rddata;
    logic [11:0]     patram_addr;
    logic [63:0]     patram_rddata;
    logic [8:0]      pmxr_pixel_addr;
    logic [8:0]      pmxr_pixel_data;
    logic [1:0]      pmxr_pixel_prio;
    logic            done;
    logic            overflow;

    modport master (
        output next_row, prep, enable, sprram_rddata, patram_rddata, pmxr_pixel_addr,
        input  sprram_addr, patram_addr, pmxr_pixel_data, pmxr_pixel_prio, done, overflow
    );

    modport slave (
        input  next_row, prep, enable, sprram_rddata, patram_rddata, pmxr_pixel_addr,
        output sprram_addr, patram_addr, pmxr_pixel_data, pmxr_pixel_prio, done, overflow
    );
endinterface

// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: clear, scan Sprite-RAM, draw hits into a line buffer; SPRITE_FLIP_EN adds h/v flip.
// Pixel reads: 1-cycle latency, one per cycle, never stall; prep aborts and restarts from any state.
module sprite_line_engine #(
    parameter int NUM_SPRITES = 64,
    parameter int MAX_PER_ROW = 16,
    parameter int LINE_WIDTH  = 320,
    parameter int SA_W        = $clog2(NUM_SPRITES)
) (
    input  logic                clk,
    input  logic                rst,
    sprite_line_engine_if.slave bus
);
    localparam int HW = $clog2(MAX_PER_ROW);
    localparam int CW = HW + 1;
    localparam int SW = SA_W + 1;
    localparam logic [SW-1:0] NS_END  = SW'(NUM_SPRITES);
    localparam logic [SW-1:0] NS_LAST = SW'(NUM_SPRITES - 1);
    localparam logic [CW-1:0] HIT_MAX = CW'(MAX_PER_ROW);
    localparam logic [8:0]    LW_LAST = 9'(LINE_WIDTH - 1);
    localparam logic [9:0]    LW10    = 10'(LINE_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAW, S_DONE} state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] tile;
        logic [3:0] prow;
        logic [4:0] pal;
        logic [1:0] prio;
`ifdef SPRITE_FLIP_EN
        logic       hflip;
        logic       vflip;
`endif
    } hit_t;

    state_t          state_q, state_d;
    logic [7:0]      row_q, row_d;
    logic            en_q, en_d;
    logic            ovf_q, ovf_d;
    logic [8:0]      clr_q, clr_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic            rdv_q, rdv_d;
    logic [SA_W-1:0] sa_q, sa_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [CW-1:0]   didx_q, didx_d;
    logic [4:0]      ph_q, ph_d;
    logic [11:0]     pa_q, pa_d;
    logic [63:0]     pat_q, pat_d;
    logic [8:0]      pix_dat_q;
    logic [1:0]      pix_pri_q;

    hit_t        hit_list [MAX_PER_ROW];
    logic [11:0] lb_mem   [LINE_WIDTH];   // {occupied, prio, palette, color}

    logic        lb_we, hit_we;
    logic [8:0]  lb_wa;
    logic [11:0] lb_wd;
    hit_t        hit_wd, cur_h, nxt_h;

    // Sprite entry decode; the hit test wraps modulo 256 so sprites straddle the top edge.
    logic [63:0] spr;
    logic [7:0]  dy;
    logic        spr_hit;
    assign spr     = bus.sprram_rddata;
    assign dy      = row_q - spr[16:9];
    assign spr_hit = (dy[7:4] == 4'd0);

`ifdef SPRITE_FLIP_EN
    logic unused_spr;
    assign unused_spr = ^spr[63:34];
`else
    logic unused_spr;
    assign unused_spr = ^spr[63:32];
`endif

    always_comb begin
        hit_wd      = '0;
        hit_wd.x    = spr[8:0];
        hit_wd.tile = spr[24:17];
        hit_wd.prow = dy[3:0];
        hit_wd.pal  = spr[29:25];
        hit_wd.prio = spr[31:30];
`ifdef SPRITE_FLIP_EN
        hit_wd.hflip = spr[32];
        hit_wd.vflip = spr[33];
`endif
    end

    function automatic logic [11:0] pat_addr(input hit_t h);
`ifdef SPRITE_FLIP_EN
        return {h.tile, h.vflip ? ~h.prow : h.prow};
`else
        return {h.tile, h.prow};
`endif
    endfunction

    // Pixel datapath: ph 2..17 draws pixel ph-2; ph 2 takes the pattern straight off the RAM.
    logic [CW-1:0] nidx;
    logic [3:0]    pix_i, src_i, color;
    logic [63:0]   cur_pat;
    logic [9:0]    col;
    logic          col_ok, col_free;

    assign nidx    = didx_q + 1'b1;
    assign cur_h   = hit_list[didx_q[HW-1:0]];
    assign nxt_h   = hit_list[nidx[HW-1:0]];
    assign pix_i   = 4'(ph_q - 5'd2);
`ifdef SPRITE_FLIP_EN
    assign src_i   = cur_h.hflip ? ~pix_i : pix_i;
`else
    assign src_i   = pix_i;
`endif
    assign cur_pat  = (ph_q == 5'd2) ? bus.patram_rddata : pat_q;
    assign color    = cur_pat[{src_i, 2'b00} +: 4];
    assign col      = {1'b0, cur_h.x} + {6'd0, pix_i};
    assign col_ok   = (col < LW10);
    assign col_free = ~lb_mem[col[8:0]][11];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        clr_d   = clr_q;
        scan_d  = scan_q;
        rdv_d   = rdv_q;
        sa_d    = sa_q;
        hcnt_d  = hcnt_q;
        didx_d  = didx_q;
        ph_d    = ph_q;
        pa_d    = pa_q;
        pat_d   = pat_q;
        lb_we   = 1'b0;
        lb_wa   = '0;
        lb_wd   = '0;
        hit_we  = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
                lb_we = 1'b1;
                lb_wa = clr_q;
                clr_d = clr_q + 1'b1;
                if (clr_q == LW_LAST) begin
                    if (en_q) begin
                        state_d = S_SCAN;
                        scan_d  = '0;
                        sa_d    = '0;
                        rdv_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                rdv_d = (scan_q != NS_END);
                if (scan_q != NS_END) begin
                    scan_d = scan_q + 1'b1;
                    if (scan_q != NS_LAST) sa_d = sa_q + 1'b1;
                end
                if (rdv_q && spr_hit) begin
                    if (hcnt_q == HIT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        hit_we = 1'b1;
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                if (scan_q == NS_END) begin
                    state_d = S_DRAW;
                    didx_d  = '0;
                    ph_d    = 5'd0;
                end
            end
            S_DRAW: begin
                if (ph_q == 5'd0) begin
                    if (didx_q == hcnt_q) begin
                        state_d = S_DONE;
                    end else begin
                        pa_d = pat_addr(cur_h);
                        ph_d = 5'd1;
                    end
                end else if (ph_q == 5'd1) begin
                    ph_d = 5'd2;
                end else begin
                    if (ph_q == 5'd2) pat_d = bus.patram_rddata;
                    if ((color != 4'd0) && col_ok && col_free) begin
                        lb_we = 1'b1;
                        lb_wa = col[8:0];
                        lb_wd = {1'b1, cur_h.prio, cur_h.pal, color};
                    end
                    if (ph_q == 5'd17) begin
                        didx_d = nidx;
                        if (nidx == hcnt_q) begin
                            state_d = S_DONE;
                        end else begin
                            pa_d = pat_addr(nxt_h);
                            ph_d = 5'd1;
                        end
                    end else begin
                        ph_d = ph_q + 5'd1;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (bus.prep) begin
            state_d = S_CLEAR;
            row_d   = bus.next_row;
            en_d    = bus.enable;
            ovf_d   = 1'b0;
            clr_d   = '0;
            hcnt_d  = '0;
            hit_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            clr_q   <= '0;
            scan_q  <= '0;
            rdv_q   <= 1'b0;
            sa_q    <= '0;
            hcnt_q  <= '0;
            didx_q  <= '0;
            ph_q    <= '0;
            pa_q    <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
            scan_q  <= scan_d;
            rdv_q   <= rdv_d;
            sa_q    <= sa_d;
            hcnt_q  <= hcnt_d;
            didx_q  <= didx_d;
            ph_q    <= ph_d;
            pa_q    <= pa_d;
            pat_q   <= pat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) lb_mem[lb_wa] <= lb_wd;
        if (hit_we) hit_list[hcnt_q[HW-1:0]] <= hit_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_dat_q <= '0;
            pix_pri_q <= '0;
        end else if ({1'b0, bus.pmxr_pixel_addr} < LW10) begin
            {pix_pri_q, pix_dat_q} <= lb_mem[bus.pmxr_pixel_addr][10:0];
        end else begin
            pix_dat_q <= '0;
            pix_pri_q <= '0;
        end
    end

    assign bus.sprram_addr     = sa_q;
    assign bus.patram_addr     = pa_q;
    assign bus.pmxr_pixel_data = pix_dat_q;
    assign bus.pmxr_pixel_prio = pix_pri_q;
    assign bus.done            = (state_q == S_DONE);
    assign bus.overflow        = ovf_q;
endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed edge cases plus random rows against a behavioural line model.
module tb_sprite_line_engine;
    localparam int NS  = 64;
    localparam int MPR = 16;
    localparam int LW  = 320;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_line_engine_if #(.SA_W(6)) bus ();

    sprite_line_engine #(
        .NUM_SPRITES(NS),
        .MAX_PER_ROW(MPR),
        .LINE_WIDTH (LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [63:0] spr_mem [NS];
    logic [63:0] pat_mem [4096];

    always @(posedge clk) begin
        bus.sprram_rddata <= spr_mem[bus.sprram_addr];
        bus.patram_rddata <= pat_mem[bus.patram_addr];
    end

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_px [LW];
    bit          exp_ovf;

    logic        rd_req   = 1'b0;
    logic        rd_vld_q = 1'b0;
    logic [19:0] sb_q [$];   // {addr, prio, data}

    always @(posedge clk) rd_vld_q <= rd_req;

    always @(negedge clk) begin
        if (rd_vld_q) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pix_unexpected: got prio=%0d data=%03h required no response",
                         bus.pmxr_pixel_prio, bus.pmxr_pixel_data);
            end else begin
                logic [19:0] e;
                e = sb_q.pop_front();
                if ({bus.pmxr_pixel_prio, bus.pmxr_pixel_data} !== e[10:0]) begin
                    failures++;
                    $display("FAIL pix[%0d]: got prio=%0d data=%03h required prio=%0d data=%03h",
                             e[19:11], bus.pmxr_pixel_prio, bus.pmxr_pixel_data, e[10:9], e[8:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] mk_spr(int x, int y, int tile, int pal, int pri, bit hf, bit vf);
        logic [63:0] v;
        v        = {$urandom, $urandom};
        v[8:0]   = x[8:0];
        v[16:9]  = y[7:0];
        v[24:17] = tile[7:0];
        v[29:25] = pal[4:0];
        v[31:30] = pri[1:0];
        v[32]    = hf;
        v[33]    = vf;
        return v;
    endfunction

    // Fill Sprite-RAM with entries that never touch the given row.
    task automatic init_spr(input int row);
        for (int s = 0; s < NS; s++)
            spr_mem[s] = mk_spr($urandom_range(0, 511), row + 100, $urandom_range(0, 255),
                                $urandom_range(0, 31), $urandom_range(0, 3), 1'b0, 1'b0);
    endtask

    // Reference: collect hits in index order, keep the first MPR, paint front-to-back.
    task automatic model(input logic [7:0] row, input bit en);
        int          n;
        int          col;
        int          src;
        logic [7:0]  dy;
        logic [3:0]  prow;
        logic [3:0]  c;
        logic [63:0] e;
        logic [63:0] pat;
        bit          occ [LW];
        for (int k = 0; k < LW; k++) begin
            exp_px[k] = '0;
            occ[k]    = 1'b0;
        end
        exp_ovf = 1'b0;
        n       = 0;
        if (!en) return;
        for (int s = 0; s < NS; s++) begin
            e  = spr_mem[s];
            dy = row - e[16:9];
            if (dy < 8'd16) begin
                if (n == MPR) begin
                    exp_ovf = 1'b1;
                end else begin
                    n++;
                    prow = dy[3:0];
`ifdef SPRITE_FLIP_EN
                    if (e[33]) prow = 4'd15 - prow;
`endif
                    pat = pat_mem[{e[24:17], prow}];
                    for (int i = 0; i < 16; i++) begin
                        src = i;
`ifdef SPRITE_FLIP_EN
                        if (e[32]) src = 15 - i;
`endif
                        c   = 4'((pat >> (4 * src)) & 64'hF);
                        col = int'(e[8:0]) + i;
                        if (c != 4'd0 && col < LW && !occ[col]) begin
                            occ[col]    = 1'b1;
                            exp_px[col] = {e[31:30], e[29:25], c};
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_prep(input logic [7:0] row, input bit en);
        bus.next_row = row;
        bus.enable   = en;
        bus.prep     = 1'b1;
        @(posedge clk);
        #1;
        bus.prep = 1'b0;
        chk("done_fall", bus.done, 1'b0);
    endtask

    // Cycle count includes the prep cycle itself.
    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_rise", bus.done, 1'b1);
    endtask

    task automatic read_line();
        int a;
        for (int k = 0; k <= LW + 8; k++) begin
            a = (k == LW + 8) ? 511 : k;
            bus.pmxr_pixel_addr = 9'(a);
            rd_req = 1'b1;
            sb_q.push_back({9'(a), (a < LW) ? exp_px[a] : 11'd0});
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic run_line(input logic [7:0] row, input bit en, output int n);
        model(row, en);
        do_prep(row, en);
        wait_done(n);
        chk("overflow", bus.overflow, exp_ovf);
        read_line();
    endtask

    initial begin
        int n;
        logic [7:0] row;
        rst = 1'b1;
        bus.prep = 1'b0;
        bus.enable = 1'b0;
        bus.next_row = '0;
        bus.pmxr_pixel_addr = '0;
        for (int a = 0; a < 4096; a++) pat_mem[a] = {$urandom, $urandom} & {$urandom, $urandom};
        init_spr(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", bus.done, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_pix_data", bus.pmxr_pixel_data, 9'd0);
        chk("rst_pix_prio", bus.pmxr_pixel_prio, 2'd0);
        chk("rst_sprram_addr", bus.sprram_addr, 6'd0);
        chk("rst_patram_addr", bus.patram_addr, 12'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single sprite with pixel i = color i.
        init_spr(5);
        spr_mem[0] = mk_spr(10, 5, 3, 7, 2, 1'b0, 1'b0);
        pat_mem[12'h030] = 64'hFEDC_BA98_7654_3210;
        run_line(8'd5, 1'b1, n);
        chk("single_patram_addr", bus.patram_addr, 12'h030);

        // Overlap: lower index wins, transparent pixels let the next sprite through.
        init_spr(50);
        spr_mem[0] = mk_spr(20, 50, 4, 1, 1, 1'b0, 1'b0);
        spr_mem[1] = mk_spr(20, 50, 5, 2, 3, 1'b0, 1'b0);
        pat_mem[{8'd4, 4'd0}] = 64'h1111_1111_1111_1111;
        pat_mem[{8'd5, 4'd0}] = 64'h2222_2222_2222_2222;
        run_line(8'd50, 1'b1, n);
        pat_mem[{8'd4, 4'd0}] = 64'h0;
        run_line(8'd50, 1'b1, n);

        // Seventeen hits on one row: the last is dropped and overflow is flagged.
        init_spr(40);
        for (int s = 0; s < 17; s++)
            spr_mem[s] = mk_spr(s * 18, 40 - (s % 16), $urandom_range(0, 255), s, s, 1'b0, 1'b0);
        run_line(8'd40, 1'b1, n);
        chk("ovf_done_bound", (n <= 660), 1'b1);

        // Right edge: opaque sprite at x=312 must not wrap into column 0.
        init_spr(60);
        spr_mem[3] = mk_spr(312, 60, 9, 5, 1, 1'b0, 1'b0);
        pat_mem[{8'd9, 4'd0}] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_line(8'd60, 1'b1, n);

        // Vertical wrap, then the same row with the layer disabled.
        init_spr(3);
        spr_mem[7] = mk_spr(40, 250, 12, 3, 1, 1'b0, 1'b0);
        run_line(8'd3, 1'b1, n);
        chk("wrap_patram_addr", bus.patram_addr, {8'd12, 4'd9});
        run_line(8'd3, 1'b0, n);
        chk("en0_latency", n, 321);

        // Flip bits set on a sprite whose first row is on next_row.
        init_spr(77);
        spr_mem[0] = mk_spr(100, 77, 20, 4, 3, 1'b1, 1'b1);
        pat_mem[{8'd20, 4'd15}] = 64'h1234_5678_9ABC_DEF1;
        pat_mem[{8'd20, 4'd0}]  = 64'h9876_5432_1FED_CBA3;
        run_line(8'd77, 1'b1, n);
`ifdef SPRITE_FLIP_EN
        chk("flip_patram_addr", bus.patram_addr, {8'd20, 4'd15});
`else
        chk("flip_patram_addr", bus.patram_addr, {8'd20, 4'd0});
`endif

        // Abort mid-DRAW with a different row.
        init_spr(90);
        for (int s = 0; s < 16; s++)
            spr_mem[s] = mk_spr(s * 20, 90 - s, $urandom_range(0, 255), s, 2, 1'b0, 1'b0);
        spr_mem[20] = mk_spr(150, 118, 33, 9, 1, 1'b0, 1'b0);
        spr_mem[21] = mk_spr(155, 120, 34, 10, 3, 1'b0, 1'b0);
        do_prep(8'd90, 1'b1);
        repeat (400) @(posedge clk);
        #1;
        chk("abort_busy", bus.done, 1'b0);
        model(8'd120, 1'b1);
        do_prep(8'd120, 1'b1);
        wait_done(n);
        chk("abort_overflow", bus.overflow, exp_ovf);
        read_line();

        // Reset in the middle of the scan.
        do_prep(8'd90, 1'b1);
        repeat (340) @(posedge clk);
        #1;
        chk("scan_active", (bus.sprram_addr != 6'd0), 1'b1);
        bus.pmxr_pixel_addr = 9'd5;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_overflow", bus.overflow, 1'b0);
        chk("mid_rst_pix_data", bus.pmxr_pixel_data, 9'd0);
        chk("mid_rst_pix_prio", bus.pmxr_pixel_prio, 2'd0);
        chk("mid_rst_sprram_addr", bus.sprram_addr, 6'd0);
        chk("mid_rst_patram_addr", bus.patram_addr, 12'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random rows with random hit density, flips and layer enable.
        for (int t = 0; t < 8; t++) begin
            int span;
            row  = 8'($urandom);
            span = $urandom_range(20, 200);
            for (int s = 0; s < NS; s++)
                spr_mem[s] = mk_spr($urandom_range(0, 340), int'(row) - $urandom_range(0, span),
                                    $urandom_range(0, 255), $urandom_range(0, 31),
                                    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            run_line(row, ($urandom_range(0, 5) != 0), n);
            chk("rand_done_bound", (n <= 660), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
